// File: rtl/tick_run_ctrl.sv
// ---------------------------------------------------------------------------
// tick_run_ctrl
//
// Single-clock run controller for the tick counter / LED blinker datapath.
// A free-running prescaler produces a one-cycle tick enable every CLK_DIV
// clock cycles while the controller is running, so no divided clocks are
// needed. Counting is sequenced by start / pause / clear commands and stops
// at a programmable terminal value.
//
// Parameters:
//   CLK_DIV  clk cycles per tick (>= 2)
//   CNT_W    width of count and limit
//
// Ports:
//   clk    in   system clock, all flops on posedge
//   rst    in   asynchronous reset, active low
//   start  in   start / resume command (one-cycle pulse)
//   pause  in   pause command
//   clear  in   clear command, highest priority
//   limit  in   terminal count, captured on a start from IDLE or DONE
//   count  out  current count (registered)
//   led    out  toggles on every tick (registered)
//   tick   out  one-cycle pulse coincident with each new count value
//   done   out  one-cycle pulse when count reaches the captured limit
//   busy   out  1 while in RUN or PAUSE
//   state  out  IDLE=0, RUN=1, PAUSE=2, DONE=3
//
// Build option:
//   TICK_AUTO_RELOAD_EN  when defined, reaching the limit pulses done but the
//                        controller stays in RUN and the next tick reloads
//                        count to 0 (0,1,..,limit,0,1,...). Only clear or
//                        pause stops counting. When undefined, reaching the
//                        limit moves to DONE and count holds.
// ---------------------------------------------------------------------------
module tick_run_ctrl #(
   parameter int CLK_DIV = 100_000,
   parameter int CNT_W   = 9
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             pause,
   input  logic             clear,
   input  logic [CNT_W-1:0] limit,
   output logic [CNT_W-1:0] count,
   output logic             led,
   output logic             tick,
   output logic             done,
   output logic             busy,
   output logic [1:0]       state
);

   // Prescaler width; CLK_DIV >= 2 keeps this at least one bit.
   localparam int PRE_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_DIV - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_PAUSE = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   logic [PRE_W-1:0] pre;
   logic [PRE_W-1:0] pre_nxt;
   logic [CNT_W-1:0] limit_q;
   logic [CNT_W-1:0] limit_q_nxt;
   logic [CNT_W-1:0] count_nxt;
   logic [CNT_W-1:0] count_inc;
   logic [1:0]       state_nxt;
   logic             led_nxt;
   logic             tick_nxt;
   logic             done_nxt;
   logic             busy_nxt;
   logic             start_cmd;

   // A start is only honoured when no pause is present, since pause outranks
   // start; clear is handled ahead of everything else in the next-state logic.
   assign start_cmd = start & ~pause;

   // Incremented count, used both for the normal tick advance and, in the
   // auto-reload build, as the non-wrapping branch of the reload mux.
   assign count_inc = count + CNT_W'(1);

   // Next-state logic for the whole controller. Everything defaults to
   // "hold", tick and done default low so they are one-cycle pulses.
   // clear wins in every state and suppresses tick/done. In RUN a pause takes
   // effect before the prescaler is examined, so a wrap landing on the same
   // cycle is dropped and the prescaler stays parked at its last value; the
   // tick then fires on the first RUN cycle after the resume.
   always_comb begin
      state_nxt   = state;
      pre_nxt     = pre;
      count_nxt   = count;
      led_nxt     = led;
      limit_q_nxt = limit_q;
      tick_nxt    = 1'b0;
      done_nxt    = 1'b0;

      if (clear) begin
         state_nxt = ST_IDLE;
         pre_nxt   = '0;
         count_nxt = '0;
         led_nxt   = 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (pause) begin
                  state_nxt = ST_PAUSE;
               end else if (pre == PRE_LAST) begin
                  pre_nxt  = '0;
                  led_nxt  = ~led;
                  tick_nxt = 1'b1;
`ifdef TICK_AUTO_RELOAD_EN
                  count_nxt = (count == limit_q) ? '0 : count_inc;
`else
                  count_nxt = count_inc;
`endif
                  if (count_nxt == limit_q) begin
                     done_nxt = 1'b1;
`ifndef TICK_AUTO_RELOAD_EN
                     state_nxt = ST_DONE;
`endif
                  end
               end else begin
                  pre_nxt = pre + PRE_W'(1);
               end
            end

            ST_PAUSE: begin
               if (start_cmd) begin
                  state_nxt = ST_RUN;
               end
            end

            default: begin
               // IDLE and DONE share the start behaviour: capture the limit,
               // restart count and prescaler phase. led is left as it is.
               if (start_cmd) begin
                  limit_q_nxt = limit;
                  count_nxt   = '0;
                  pre_nxt     = '0;
`ifdef TICK_AUTO_RELOAD_EN
                  state_nxt   = ST_RUN;
`else
                  if (limit == '0) begin
                     state_nxt = ST_DONE;
                     done_nxt  = 1'b1;
                  end else begin
                     state_nxt = ST_RUN;
                  end
`endif
               end
            end
         endcase
      end

      busy_nxt = (state_nxt == ST_RUN) || (state_nxt == ST_PAUSE);
   end

   // All controller state lives in one register bank so state and busy are
   // always updated on the same edge and can never disagree.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         pre     <= '0;
         count   <= '0;
         limit_q <= '0;
         led     <= 1'b0;
         tick    <= 1'b0;
         done    <= 1'b0;
         busy    <= 1'b0;
      end else begin
         state   <= state_nxt;
         pre     <= pre_nxt;
         count   <= count_nxt;
         limit_q <= limit_q_nxt;
         led     <= led_nxt;
         tick    <= tick_nxt;
         done    <= done_nxt;
         busy    <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_tick_run_ctrl.sv
// ---------------------------------------------------------------------------
// tb_tick_run_ctrl
//
// Self-checking bench for tick_run_ctrl with CLK_DIV=4, CNT_W=9. A reference
// model tracks how many uninterrupted RUN cycles have elapsed since the last
// start and derives tick, count and led from that number arithmetically. A
// negedge process compares every DUT output with the model each cycle, and
// directed sequences pin the model with hand-computed literal values before
// a long randomized phase.
// ---------------------------------------------------------------------------
module tb_tick_run_ctrl;

   localparam int CLK_DIV = 4;
   localparam int CNT_W   = 9;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start = 1'b0;
   logic             pause = 1'b0;
   logic             clear = 1'b0;
   logic [CNT_W-1:0] limit = '0;
   logic [CNT_W-1:0] count;
   logic             led;
   logic             tick;
   logic             done;
   logic             busy;
   logic [1:0]       state;

   int checkCount = 0;
   int passCount  = 0;
   bit checkEn    = 1'b0;

   tick_run_ctrl #(
      .CLK_DIV(CLK_DIV),
      .CNT_W  (CNT_W)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .pause(pause),
      .clear(clear),
      .limit(limit),
      .count(count),
      .led  (led),
      .tick (tick),
      .done (done),
      .busy (busy),
      .state(state)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Reference model. mState: 0 idle, 1 run, 2 pause, 3 done.
   // runCyc counts RUN cycles that advanced the prescaler since the last
   // start; every CLK_DIV of them is one tick. ledBase is the led value at
   // the last start, so led is ledBase flipped once per tick.
   int mState  = 0;
   int runCyc  = 0;
   int ticks   = 0;
   int limQ    = 0;
   int ledBase = 0;
   int expTick = 0;
   int expDone = 0;

   function automatic int modelCount();
`ifdef TICK_AUTO_RELOAD_EN
      return ticks % (limQ + 1);
`else
      return ticks;
`endif
   endfunction

   function automatic int modelLed();
      return ledBase ^ (ticks & 1);
   endfunction

   // Model update on each clock edge, reset asynchronously like the DUT.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mState  = 0;
         runCyc  = 0;
         ticks   = 0;
         limQ    = 0;
         ledBase = 0;
         expTick = 0;
         expDone = 0;
      end else begin
         expTick = 0;
         expDone = 0;
         if (clear) begin
            mState  = 0;
            runCyc  = 0;
            ticks   = 0;
            ledBase = 0;
         end else if (mState == 1) begin
            if (pause) begin
               mState = 2;
            end else begin
               runCyc = runCyc + 1;
               if (runCyc % CLK_DIV == 0) begin
                  ticks   = runCyc / CLK_DIV;
                  expTick = 1;
                  if (modelCount() == limQ) begin
                     expDone = 1;
`ifndef TICK_AUTO_RELOAD_EN
                     mState = 3;
`endif
                  end
               end
            end
         end else if (mState == 2) begin
            if (start && !pause) mState = 1;
         end else if (start && !pause) begin
            ledBase = modelLed();
            limQ    = int'(limit);
            runCyc  = 0;
            ticks   = 0;
            mState  = 1;
`ifndef TICK_AUTO_RELOAD_EN
            if (limQ == 0) begin
               mState  = 3;
               expDone = 1;
            end
`endif
         end
      end
   end

   // Single comparison point; prints a FAIL line on any difference.
   task automatic checkOutput(input string name, input int actual, input int expected);
      checkCount++;
      if (actual == expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got %0d expected %0d at time %0t", name, actual, expected, $time);
      end
   endtask

   // Drive one cycle of inputs, let one rising edge sample them, and return
   // just after that edge so the outputs reflect it.
   task automatic applyStimulus(input logic s, input logic p, input logic c, input logic [CNT_W-1:0] l);
      start = s;
      pause = p;
      clear = c;
      limit = l;
      @(posedge clk);
      #1;
   endtask

   task automatic idleCycles(input int n, input logic [CNT_W-1:0] l);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, l);
   endtask

   // Cycle-by-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("model.state", int'(state), mState);
         checkOutput("model.busy", int'(busy), int'(mState == 1 || mState == 2));
         checkOutput("model.count", int'(count), modelCount());
         checkOutput("model.led", int'(led), modelLed());
         checkOutput("model.tick", int'(tick), expTick);
         checkOutput("model.done", int'(done), expDone);
      end
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int r;
      logic s;
      logic p;
      logic c;

      // Power-on reset and reset-value checks.
      #1 rst = 1'b0;
      #1 checkEn = 1'b1;
      #1;
      checkOutput("reset.count", int'(count), 0);
      checkOutput("reset.state", int'(state), 0);
      checkOutput("reset.busy", int'(busy), 0);
      checkOutput("reset.tick", int'(tick), 0);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;

      // Asynchronous reset in the middle of a run at count=2.
      applyStimulus(1'b1, 1'b0, 1'b0, 9'd5);
      idleCycles(8, 9'd5);
      checkOutput("rstrun.count_before", int'(count), 2);
      #2 rst = 1'b0;
      #1;
      checkOutput("rstrun.count", int'(count), 0);
      checkOutput("rstrun.led", int'(led), 0);
      checkOutput("rstrun.state", int'(state), 0);
      checkOutput("rstrun.busy", int'(busy), 0);
      checkOutput("rstrun.tick", int'(tick), 0);
      @(posedge clk);
      #1 rst = 1'b1;
      for (int k = 0; k < 6; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 9'd5);
         checkOutput("rstrun.idle_state", int'(state), 0);
         checkOutput("rstrun.idle_tick", int'(tick), 0);
      end

`ifndef TICK_AUTO_RELOAD_EN
      // Basic run to limit 3: ticks on RUN cycles 4, 8, 12.
      applyStimulus(1'b1, 1'b0, 1'b0, 9'd3);
      checkOutput("basic.state_run", int'(state), 1);
      for (int k = 1; k <= 12; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 9'd3);
         checkOutput("basic.tick", int'(tick), int'(k % 4 == 0));
         checkOutput("basic.done", int'(done), int'(k == 12));
         if (k % 4 == 0) begin
            checkOutput("basic.count", int'(count), k / 4);
            checkOutput("basic.led", int'(led), (k / 4) & 1);
         end
      end
      checkOutput("basic.state_done", int'(state), 3);
      checkOutput("basic.busy_done", int'(busy), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 9'd3);
      checkOutput("basic.count_hold", int'(count), 3);
      checkOutput("basic.done_once", int'(done), 0);
`endif

      // Pause two cycles after the count=1 tick, hold, then resume.
      applyStimulus(1'b1, 1'b0, 1'b0, 9'd6);
      idleCycles(4, 9'd6);
      checkOutput("pause.count1", int'(count), 1);
      idleCycles(2, 9'd6);
      applyStimulus(1'b0, 1'b1, 1'b0, 9'd6);
      checkOutput("pause.state", int'(state), 2);
      for (int k = 0; k < 10; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 9'd6);
         checkOutput("pause.no_tick", int'(tick), 0);
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 9'd6);
      checkOutput("pause.resume_state", int'(state), 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 9'd6);
      checkOutput("pause.resume_tick1", int'(tick), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 9'd6);
      checkOutput("pause.resume_tick2", int'(tick), 1);
      checkOutput("pause.count2", int'(count), 2);

      // clear together with start while running at count=2.
      applyStimulus(1'b1, 1'b0, 1'b1, 9'd6);
      checkOutput("prio.state", int'(state), 0);
      checkOutput("prio.count", int'(count), 0);
      checkOutput("prio.led", int'(led), 0);
      checkOutput("prio.tick", int'(tick), 0);
      checkOutput("prio.done", int'(done), 0);

      // pause landing on a prescaler wrap drops that tick.
      applyStimulus(1'b1, 1'b0, 1'b0, 9'd6);
      idleCycles(3, 9'd6);
      applyStimulus(1'b0, 1'b1, 1'b0, 9'd6);
      checkOutput("pwrap.tick", int'(tick), 0);
      checkOutput("pwrap.count", int'(count), 0);
      applyStimulus(1'b1, 1'b0, 1'b0, 9'd6);
      checkOutput("pwrap.resume_tick", int'(tick), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 9'd6);
      checkOutput("pwrap.first_tick", int'(tick), 1);
      checkOutput("pwrap.count1", int'(count), 1);
      applyStimulus(1'b0, 1'b0, 1'b1, 9'd6);

`ifndef TICK_AUTO_RELOAD_EN
      // Zero limit goes straight to DONE with a single done pulse.
      applyStimulus(1'b1, 1'b0, 1'b0, 9'd0);
      checkOutput("zero.state", int'(state), 3);
      checkOutput("zero.done", int'(done), 1);
      checkOutput("zero.tick", int'(tick), 0);
      checkOutput("zero.count", int'(count), 0);
      applyStimulus(1'b0, 1'b0, 1'b0, 9'd0);
      checkOutput("zero.done_once", int'(done), 0);
      checkOutput("zero.tick_after", int'(tick), 0);
`else
      // Auto reload with limit 2: count 1,2,0,1,2 and done on each count=2.
      applyStimulus(1'b1, 1'b0, 1'b0, 9'd2);
      for (int k = 1; k <= 20; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 9'd2);
         checkOutput("auto.state", int'(state), 1);
         if (k % 4 == 0) begin
            checkOutput("auto.count", int'(count), (k / 4) % 3);
            checkOutput("auto.done", int'(done), int'((k / 4) % 3 == 2));
         end
      end
      applyStimulus(1'b0, 1'b0, 1'b1, 9'd2);
      checkOutput("auto.clear_state", int'(state), 0);
`endif

      // Randomized commands, limits and occasional asynchronous resets.
      for (int i = 0; i < 4000; i++) begin
         r = int'($urandom_range(0, 999));
         if (r < 6) begin
            rst = 1'b0;
            applyStimulus(1'b0, 1'b0, 1'b0, limit);
            rst = 1'b1;
         end else begin
            c = (r < 50);
            p = (r >= 50 && r < 120);
            s = (r >= 120 && r < 300);
            applyStimulus(s, p, c, CNT_W'($urandom_range(0, 10)));
         end
      end
      idleCycles(2, '0);

      checkEn = 1'b0;
      $display("[TB] %0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
